cbus_rr_arbiter: RTL and testbench



---
 rtl/cbus_rr_arbiter_pkg.sv | 30 +++
 rtl/cbus_rr_arbiter_rr_picker.sv | 35 +++
 rtl/cbus_rr_arbiter.sv | 97 +++++++++
 tb/tb_cbus_rr_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_rr_arbiter_pkg.sv
// cbus_rr_arbiter_pkg: cbus request/response types, arbiter state and burst length helpers
package cbus_rr_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [3:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    localparam logic [3:0] MLEN1  = 4'd0;
    localparam logic [3:0] MLEN2  = 4'd1;
    localparam logic [3:0] MLEN4  = 4'd3;
    localparam logic [3:0] MLEN8  = 4'd7;
    localparam logic [3:0] MLEN16 = 4'd15;

    function automatic logic [4:0] len_to_beats(input logic [3:0] len);
        return {1'b0, len} + 5'd1;
    endfunction

endpackage

// File: rtl/cbus_rr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first valid index at or after i_prio
//   i_valid  in  NUM_REQ  request valid vector
//   i_prio   in  IDX_W    index scanned first
//   o_pick   out IDX_W    chosen index (meaningful only when o_any)
//   o_any    out 1        at least one valid
module rr_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_valid,
    input  logic [$clog2(NUM_REQ)-1:0] i_prio,
    output logic [$clog2(NUM_REQ)-1:0] o_pick,
    output logic                       o_any
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]     w_off;
    logic [IDX_W:0]       w_sum;

    // rotating the doubled vector puts i_prio at bit 0, so the lowest set bit is the scan offset
    assign w_dbl = {i_valid, i_valid};
    assign w_rot = NUM_REQ'(w_dbl >> i_prio);

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (w_rot[k]) w_off = IDX_W'(k);
    end

    assign w_sum  = {1'b0, i_prio} + {1'b0, w_off};
    assign o_pick = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ)) : w_sum[IDX_W-1:0];
    assign o_any  = |i_valid;

endmodule

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: round-robin burst arbiter sharing one cbus between NUM_REQ masters
//   clk        in   1                    clock
//   reset      in   1                    asynchronous active-high reset
//   ireqs      in   NUM_REQ x cbus_req_t requester requests, index 0 first after reset
//   iresps     out  NUM_REQ x cbus_resp_t per-requester responses, only the owner sees oresp
//   oreq       out  cbus_req_t           request forwarded to memory side
//   oresp      in   cbus_resp_t          response from memory side
//   grant      out  NUM_REQ              one-hot owner, zero when idle
//   proto_err  out  1                    sticky protocol violation flag
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  cbus_req_t  [NUM_REQ-1:0]      ireqs,
    output cbus_resp_t [NUM_REQ-1:0]      iresps,
    output cbus_req_t                     oreq,
    input  cbus_resp_t                    oresp,
    output logic       [NUM_REQ-1:0]      grant,
    output logic                          proto_err
);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_prio;
    logic [3:0]       r_blen;
    logic [3:0]       r_beat;
    logic             r_err;

    logic [NUM_REQ-1:0] w_valid;
    logic [IDX_W-1:0]   w_pick;
    logic               w_any;
    logic               w_final;

    always_comb begin
        w_valid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_valid[i] = ireqs[i].valid;
    end

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_valid (w_valid),
        .i_prio  (r_prio),
        .o_pick  (w_pick),
        .o_any   (w_any)
    );

    // true when the current beat is the last one the latched length allows
    assign w_final = ({1'b0, r_beat} + 5'd1) == len_to_beats(r_blen);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_prio  <= '0;
            r_blen  <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (oresp.ready) r_err <= 1'b1;
            if (w_any) begin
                r_owner <= w_pick;
                r_blen  <= ireqs[w_pick].len;
                r_beat  <= '0;
                r_state <= BUSY;
            end
        end else begin
            if (!oreq.valid) r_err <= 1'b1;
            if (oresp.ready) begin
                r_beat <= (r_beat == 4'hf) ? r_beat : r_beat + 4'd1;
                if (oresp.last != w_final) r_err <= 1'b1;
                if (oresp.last) begin
                    r_state <= IDLE;
                    r_prio  <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
                end
            end
        end
    end

    // outputs decode from the async-reset state, so reset silences the bus without a clock edge
    always_comb begin
        oreq   = '0;
        iresps = '0;
        grant  = '0;
        if (r_state == BUSY) begin
            oreq            = ireqs[r_owner];
            iresps[r_owner] = oresp;
            grant[r_owner]  = 1'b1;
        end
    end

    assign proto_err = r_err;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: directed self-checking bench for cbus_rr_arbiter (2- and 3-requester builds)
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cbus_req_t  [1:0] ireqs;
    cbus_resp_t [1:0] iresps;
    cbus_req_t        oreq;
    cbus_resp_t       oresp;
    logic       [1:0] grant;
    logic             proto_err;

    cbus_req_t  [2:0] ireqs3;
    cbus_resp_t [2:0] iresps3;
    cbus_req_t        oreq3;
    cbus_resp_t       oresp3;
    logic       [2:0] grant3;
    logic             proto_err3;

    cbus_rr_arbiter #(.NUM_REQ(2)) dut (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps),
        .oreq(oreq), .oresp(oresp), .grant(grant), .proto_err(proto_err)
    );

    cbus_rr_arbiter #(.NUM_REQ(3)) dut3 (
        .clk(clk), .reset(reset), .ireqs(ireqs3), .iresps(iresps3),
        .oreq(oreq3), .oresp(oresp3), .grant(grant3), .proto_err(proto_err3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cbus_req_t mkreq(input logic [3:0] len, input logic [31:0] addr);
        cbus_req_t r;
        r = '0;
        r.valid = 1'b1;
        r.len   = len;
        r.addr  = addr;
        return r;
    endfunction

    function automatic cbus_resp_t mkresp(input logic last, input logic [31:0] data);
        cbus_resp_t r;
        r.ready = 1'b1;
        r.last  = last;
        r.data  = data;
        return r;
    endfunction

    // drives n ready beats (last on the final one) to dut, checking owner-only response routing
    task automatic burst2(input int n, input int owner, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            oresp = mkresp(i == n - 1, d + 32'(i));
            #1;
            chk("own_data", 64'(iresps[owner].data), 64'(d + 32'(i)));
            chk("other_zero", 64'(iresps[1-owner]), 64'd0);
            @(negedge clk);
        end
        oresp = '0;
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        ireqs = '0; oresp = '0; ireqs3 = '0; oresp3 = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ireqs = '0; oresp = '0; ireqs3 = '0; oresp3 = '0;
        @(negedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_oreq", 64'(oreq), 64'd0);
        chk("rst_err", 64'(proto_err), 64'd0);
        reset = 1'b0;

        // single MLEN16 read burst from requester 1
        ireqs[1] = mkreq(MLEN16, 32'h8000_0040);
        #1;
        chk("single_idle_grant", 64'(grant), 64'd0);
        @(negedge clk);
        #1;
        chk("single_grant", 64'(grant), 64'b10);
        chk("single_valid", 64'(oreq.valid), 64'd1);
        chk("single_addr", 64'(oreq.addr), 64'h8000_0040);
        chk("single_len", 64'(oreq.len), 64'(MLEN16));
        burst2(16, 1, 32'h100);
        chk("single_back_idle", 64'(grant), 64'd0);
        ireqs[1] = '0;
        @(negedge clk);
        #1;
        chk("single_stay_idle", 64'(grant), 64'd0);
        chk("single_err", 64'(proto_err), 64'd0);

        // contention: both MLEN4, alternating grants with a bubble between bursts
        ireqs[0] = mkreq(MLEN4, 32'h0000_1000);
        ireqs[1] = mkreq(MLEN4, 32'h0000_2000);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_grant", 64'(grant), (k % 2 == 0) ? 64'b01 : 64'b10);
            chk("cont_addr", 64'(oreq.addr), (k % 2 == 0) ? 64'h1000 : 64'h2000);
            burst2(4, k % 2, 32'hDEAD_BEEF);
            chk("cont_bubble", 64'(grant), 64'd0);
            if (k == 3) ireqs = '0;
            @(negedge clk);
        end
        #1;
        chk("cont_err", 64'(proto_err), 64'd0);
        chk("cont_idle", 64'(grant), 64'd0);

        // last arrives on beat 2 of an MLEN4 burst
        ireqs[0] = mkreq(MLEN4, 32'h0000_3000);
        @(negedge clk);
        oresp = mkresp(1'b0, 32'h1);
        @(negedge clk);
        oresp = mkresp(1'b1, 32'h2);
        @(negedge clk);
        ireqs = '0; oresp = '0;
        #1;
        chk("short_err", 64'(proto_err), 64'd1);
        chk("short_idle", 64'(grant), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("short_sticky", 64'(proto_err), 64'd1);
        do_reset();
        #1;
        chk("short_cleared", 64'(proto_err), 64'd0);

        // async reset after beat 5 of a 16-beat burst
        ireqs[1] = mkreq(MLEN16, 32'h0000_4000);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            oresp = mkresp(1'b0, 32'h55);
            @(negedge clk);
        end
        #2;
        chk("pre_arst_grant", 64'(grant), 64'b10);
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(oreq.valid), 64'd0);
        chk("arst_grant", 64'(grant), 64'd0);
        chk("arst_iresps", 64'(iresps), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        oresp = '0;
        ireqs[0] = mkreq(MLEN1, 32'h0000_5000);
        ireqs[1] = mkreq(MLEN1, 32'h0000_6000);
        @(negedge clk);
        #1;
        chk("arst_first_grant", 64'(grant), 64'b01);
        chk("arst_no_err", 64'(proto_err), 64'd0);

        // ready with no last on the final beat of an MLEN1 burst
        oresp = mkresp(1'b0, 32'h7);
        @(negedge clk);
        oresp = '0;
        #1;
        chk("nolast_err", 64'(proto_err), 64'd1);

        // ready seen while idle
        do_reset();
        oresp = mkresp(1'b0, 32'h0);
        @(negedge clk);
        oresp = '0;
        #1;
        chk("idle_ready_err", 64'(proto_err), 64'd1);
        chk("idle_ready_grant", 64'(grant), 64'd0);

        // valid dropped mid-burst: grant held, error flagged
        do_reset();
        ireqs[0] = mkreq(MLEN4, 32'h0000_7000);
        @(negedge clk);
        ireqs[0].valid = 1'b0;
        @(negedge clk);
        #1;
        chk("drop_grant_held", 64'(grant), 64'b01);
        chk("drop_err", 64'(proto_err), 64'd1);

        // three requesters, all valid with single-beat bursts: 0,1,2,0
        do_reset();
        ireqs3[0] = mkreq(MLEN1, 32'h0);
        ireqs3[1] = mkreq(MLEN1, 32'h4);
        ireqs3[2] = mkreq(MLEN1, 32'h8);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("wrap_grant", 64'(grant3), 64'(3'b001 << (k % 3)));
            chk("wrap_addr", 64'(oreq3.addr), 64'(4 * (k % 3)));
            oresp3 = mkresp(1'b1, 32'hA0 + 32'(k));
            #1;
            chk("wrap_data", 64'(iresps3[k % 3].data), 64'(32'hA0 + 32'(k)));
            @(negedge clk);
            oresp3 = '0;
            #1;
            chk("wrap_bubble", 64'(grant3), 64'd0);
            @(negedge clk);
        end
        #1;
        chk("wrap_err", 64'(proto_err3), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
